// File: rtl/dac_wavegen.sv
// Phase-accumulator waveform generator feeding an 8-bit DAC: saw, triangle, square and DC
// shapes, amplitude-scaled, with a shadowed step that only takes effect on phase wrap.
module dac_wavegen #(
   parameter int unsigned ACC_W  = 16,
   parameter int unsigned CODE_W = 8
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              tick,
   input  logic              cfg_we,
   input  logic [1:0]        cfg_addr,
   input  logic [7:0]        cfg_data,
   output logic [CODE_W-1:0] code,
   output logic              code_stb,
   output logic              wrap
);

   typedef enum logic [1:0] {
      ModeSaw    = 2'd0,
      ModeTri    = 2'd1,
      ModeSquare = 2'd2,
      ModeDc     = 2'd3
   } mode_e;

   logic [15:0]       shadow_q, shadow_d;
   logic [15:0]       active_q, active_d;
   logic [ACC_W-1:0]  phase_q, phase_d;
   mode_e             mode_q, mode_d;
   logic [7:0]        amp_q, amp_d;
   logic              adv_q, adv_d;
   logic              wrap_q, wrap_d;
   logic [CODE_W-1:0] code_q, code_d;
   logic              stb_q;

   logic              mode_wr;
   logic [ACC_W-1:0]  step_ext;
   logic [ACC_W:0]    sum;
   logic [7:0]        p, t, raw;
   logic [15:0]       prod;

   assign mode_wr  = cfg_we && (cfg_addr == 2'd2);
   assign step_ext = ACC_W'(active_q);
   assign sum      = {1'b0, phase_q} + {1'b0, step_ext};

   // Phase, step and configuration next state
   always_comb begin
      shadow_d = shadow_q;
      active_d = active_q;
      phase_d  = phase_q;
      mode_d   = mode_q;
      amp_d    = amp_q;
      adv_d    = 1'b0;
      wrap_d   = 1'b0;
      if (tick) begin
         if (active_q == 16'd0) begin
            active_d = shadow_q;
         end else if (!mode_wr) begin
            phase_d = sum[ACC_W-1:0];
            adv_d   = 1'b1;
            wrap_d  = sum[ACC_W];
            // shadow_q is the pre-write value, so a same-edge step write lands next wrap
            if (sum[ACC_W]) active_d = shadow_q;
         end
      end
      if (cfg_we) begin
         unique case (cfg_addr)
            2'd0: shadow_d[7:0]  = cfg_data;
            2'd1: shadow_d[15:8] = cfg_data;
            2'd2: begin
               mode_d  = mode_e'(cfg_data[1:0]);
               phase_d = '0;
            end
            2'd3: amp_d = cfg_data;
            default: ;
         endcase
      end
   end

   // Waveform shaping and amplitude scaling from the already-advanced phase
   always_comb begin
      p = phase_q[ACC_W-1 -: 8];
      t = phase_q[ACC_W-2 -: 8];
      unique case (mode_q)
         ModeSaw:    raw = p;
         ModeTri:    raw = phase_q[ACC_W-1] ? ~t : t;
         ModeSquare: raw = phase_q[ACC_W-1] ? 8'hFF : 8'h00;
         ModeDc:     raw = 8'hFF;
         default:    raw = 8'h00;
      endcase
      prod   = {8'd0, raw} * ({8'd0, amp_q} + 16'd1);
      code_d = adv_q ? CODE_W'(prod[15:8]) : code_q;
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         shadow_q <= '0;
         active_q <= '0;
         phase_q  <= '0;
         mode_q   <= ModeSaw;
         amp_q    <= 8'hFF;
         adv_q    <= 1'b0;
         wrap_q   <= 1'b0;
         code_q   <= '0;
         stb_q    <= 1'b0;
      end else begin
         shadow_q <= shadow_d;
         active_q <= active_d;
         phase_q  <= phase_d;
         mode_q   <= mode_d;
         amp_q    <= amp_d;
         adv_q    <= adv_d;
         wrap_q   <= wrap_d;
         code_q   <= code_d;
         stb_q    <= adv_q;
      end
   end

   assign code     = code_q;
   assign code_stb = stb_q;
   assign wrap     = wrap_q;

endmodule

// File: tb/tb_dac_wavegen.sv
// Randomised and directed bench for dac_wavegen against an arithmetic waveform model.
module tb_dac_wavegen;

   localparam int ACC_W = 16;
   localparam int unsigned MODV = 32'd1 << ACC_W;

   logic       clk = 1'b0;
   logic       n_rst = 1'b0;
   logic       tick = 1'b0;
   logic       cfg_we = 1'b0;
   logic [1:0] cfg_addr = 2'd0;
   logic [7:0] cfg_data = 8'd0;
   logic [7:0] code;
   logic       code_stb;
   logic       wrap;

   dac_wavegen #(.ACC_W(ACC_W), .CODE_W(8)) dut (
      .clk(clk), .n_rst(n_rst), .tick(tick), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
      .cfg_data(cfg_data), .code(code), .code_stb(code_stb), .wrap(wrap)
   );

   always #50 clk = ~clk;

   int total = 0;
   int bad = 0;

   // Reference model state
   int unsigned m_shadow, m_active, m_phase, m_mode, m_amp, m_code;
   bit          m_adv, m_stb, m_wrap;
   int unsigned got[$];

   function automatic int unsigned ref_code(int unsigned ph, int unsigned md, int unsigned amp);
      int unsigned raw, t, half;
      half = MODV / 2;
      t = (ph >> (ACC_W - 9)) % 256;
      case (md)
         0: raw = ph >> (ACC_W - 8);
         1: raw = (ph >= half) ? 255 - t : t;
         2: raw = (ph >= half) ? 255 : 0;
         default: raw = 255;
      endcase
      return (raw * (amp + 1)) / 256;
   endfunction

   task automatic model_reset();
      m_shadow = 0; m_active = 0; m_phase = 0; m_mode = 0; m_amp = 255; m_code = 0;
      m_adv = 0; m_stb = 0; m_wrap = 0;
   endtask

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive, advance model at the edge, compare outputs after the edge.
   task automatic cyc(bit tk, bit we = 1'b0, bit [1:0] a = 2'd0, bit [7:0] d = 8'd0);
      int unsigned old_sh, nxt;
      tick = tk; cfg_we = we; cfg_addr = a; cfg_data = d;
      @(posedge clk);
      m_stb = m_adv;
      if (m_adv) m_code = ref_code(m_phase, m_mode, m_amp);
      m_wrap = 0; m_adv = 0;
      old_sh = m_shadow;
      if (tk) begin
         if (m_active == 0) m_active = old_sh;
         else if (!(we && a == 2'd2)) begin
            nxt = m_phase + (m_active % MODV);
            if (nxt >= MODV) begin
               m_wrap = 1;
               m_active = old_sh;
            end
            m_phase = nxt % MODV;
            m_adv = 1;
         end
      end
      if (we) begin
         case (a)
            2'd0: m_shadow = (m_shadow & 32'hFF00) | d;
            2'd1: m_shadow = (m_shadow & 32'h00FF) | (32'(d) << 8);
            2'd2: begin m_mode = d % 4; m_phase = 0; end
            default: m_amp = d;
         endcase
      end
      #1;
      tick = 1'b0; cfg_we = 1'b0;
      check("code_stb", 32'(code_stb), 32'(m_stb));
      check("wrap", 32'(wrap), 32'(m_wrap));
      check("code", 32'(code), m_code);
      if (code_stb === 1'b1) got.push_back(32'(code));
   endtask

   task automatic set_step(bit [15:0] s);
      cyc(1'b0, 1'b1, 2'd0, s[7:0]);
      cyc(1'b0, 1'b1, 2'd1, s[15:8]);
   endtask

   // Tick until the model wraps so the shadow step becomes active.
   task automatic wrap_load();
      bit seen = 0;
      for (int i = 0; i < 80 && !seen; i++) begin
         cyc(1'b1);
         seen = m_wrap;
      end
      check("wrap_bound", 32'(seen), 32'd1);
   endtask

   task automatic expect_codes(string tag, int unsigned exp[$]);
      check({tag, "_count"}, got.size(), exp.size());
      for (int i = 0; i < exp.size() && i < got.size(); i++) check(tag, got[i], exp[i]);
   endtask

   initial begin
      int unsigned exp[$];
      int          wraps, wrap_idx;
      model_reset();
      #20;
      check("rst_code", 32'(code), 32'd0);
      check("rst_stb", 32'(code_stb), 32'd0);
      check("rst_wrap", 32'(wrap), 32'd0);
      @(posedge clk); #10 n_rst = 1'b1;

      // Saw: load tick then 16 back-to-back ticks
      set_step(16'h1000);
      cyc(1'b1);
      check("load_no_stb_pending", 32'(m_adv), 32'd0);
      got.delete(); wraps = 0; wrap_idx = 0;
      for (int i = 1; i <= 16; i++) begin
         cyc(1'b1);
         if (wrap === 1'b1) begin wraps++; wrap_idx = i; end
      end
      cyc(1'b0); cyc(1'b0);
      exp.delete();
      for (int i = 1; i <= 16; i++) exp.push_back((i * 16) % 256);
      expect_codes("saw", exp);
      check("saw_wraps", 32'(wraps), 32'd1);
      check("saw_wrap_idx", 32'(wrap_idx), 32'd16);

      // Asynchronous reset mid-waveform at phase 0x7000
      for (int i = 0; i < 7; i++) cyc(1'b1);
      cyc(1'b0); cyc(1'b0);
      check("pre_rst_code", 32'(code), 32'h70);
      #20 n_rst = 1'b0;
      #1;
      model_reset();
      check("mid_rst_code", 32'(code), 32'd0);
      check("mid_rst_stb", 32'(code_stb), 32'd0);
      check("mid_rst_wrap", 32'(wrap), 32'd0);
      @(posedge clk); #10 n_rst = 1'b1;
      // Amplitude must be back at 0xFF: DC mode gives full scale
      cyc(1'b0, 1'b1, 2'd2, 8'd3);
      set_step(16'h4000);
      cyc(1'b1);
      got.delete();
      cyc(1'b1); cyc(1'b0); cyc(1'b0);
      expect_codes("rst_amp_dc", '{32'hFF});

      // Triangle, step 0x4000
      cyc(1'b0, 1'b1, 2'd2, 8'd1);
      got.delete();
      for (int i = 0; i < 4; i++) cyc(1'b1);
      cyc(1'b0); cyc(1'b0);
      expect_codes("tri", '{32'h80, 32'hFF, 32'h7F, 32'h00});

      // Square with amplitude 0x7F, step 0x8000
      cyc(1'b0, 1'b1, 2'd3, 8'h7F);
      set_step(16'h8000);
      wrap_load();
      cyc(1'b0, 1'b1, 2'd2, 8'd2);
      got.delete();
      for (int i = 0; i < 4; i++) cyc(1'b1);
      cyc(1'b0); cyc(1'b0);
      expect_codes("square", '{32'h7F, 32'h00, 32'h7F, 32'h00});

      // DC with amplitude 0x40
      cyc(1'b0, 1'b1, 2'd3, 8'h40);
      cyc(1'b0, 1'b1, 2'd2, 8'd3);
      got.delete();
      for (int i = 0; i < 3; i++) cyc(1'b1);
      cyc(1'b0); cyc(1'b0);
      expect_codes("dc", '{32'h40, 32'h40, 32'h40});

      // Step change at phase 0x3000, then a wrap coinciding with a shadow write
      cyc(1'b0, 1'b1, 2'd3, 8'hFF);
      set_step(16'h1000);
      wrap_load();
      cyc(1'b0, 1'b1, 2'd2, 8'd0);
      for (int i = 0; i < 3; i++) cyc(1'b1);
      set_step(16'h2000);
      got.delete();
      for (int i = 0; i < 15; i++) cyc(1'b1);
      cyc(1'b0); cyc(1'b0);
      check("stepchg_last", got[$], 32'h40);
      check("stepchg_wrapcode", got[12], 32'h00);
      for (int i = 0; i < 5; i++) cyc(1'b1);
      cyc(1'b1, 1'b1, 2'd1, 8'h30);
      got.delete();
      cyc(1'b1); cyc(1'b0); cyc(1'b0);
      expect_codes("coincide_old_shadow", '{32'h00, 32'h20});

      // Mode write with tick in the same cycle
      cyc(1'b1, 1'b1, 2'd2, 8'd0);
      got.delete();
      cyc(1'b0);
      check("modewr_no_stb", got.size(), 32'd0);
      cyc(1'b1); cyc(1'b0); cyc(1'b0);
      expect_codes("modewr_next", '{32'h20});

      // Randomised traffic against the model
      for (int i = 0; i < 400; i++) begin
         bit tk, we;
         tk = ($urandom % 4) != 0;
         we = ($urandom % 6) == 0;
         cyc(tk, we, 2'($urandom % 4), 8'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/dac_wavegen.md
DAC_WAVEGEN -- requirements
Module: dac_wavegen

Interface
REQ-001 SHALL have parameter ACC_W, default 16: phase accumulator width, legal range 10-24.
REQ-002 SHALL have parameter CODE_W, default 8: DAC code width, fixed at 8 for this tapeout.
REQ-003 SHALL have port clk, input, 1 bit: single system clock, 10 MHz nominal; the only clock in the block.
REQ-004 SHALL have port n_rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port tick, input, 1 bit: sample-advance strobe, one clk cycle wide, driven by the clock-divider zero-count pulse.
REQ-006 SHALL have port cfg_we, input, 1 bit: configuration write strobe.
REQ-007 SHALL have port cfg_addr, input, 2 bits: register select. 0 = step[7:0], 1 = step[15:8], 2 = mode[1:0], 3 = amplitude.
REQ-008 SHALL have port cfg_data, input, 8 bits: configuration write data.
REQ-009 SHALL have port code, output, 8 bits: registered DAC code, feeding the DAC controller data input.
REQ-010 SHALL have port code_stb, output, 1 bit: one-cycle pulse that marks a new code.
REQ-011 SHALL have port wrap, output, 1 bit: one-cycle pulse on phase accumulator wrap.

Function
REQ-012 SHALL hold these registers: shadow step (16 bits), active step (16 bits), phase accumulator (ACC_W bits), mode (2 bits), amplitude (8 bits).
REQ-013 SHALL write a cfg_we write at addresses 0 and 1 into the shadow step only; the active step SHALL NOT change on that write.
REQ-014 SHALL load shadow into active, when active is nonzero, only on the same edge where a tick causes the phase to wrap.
REQ-015 SHALL treat a tick with active = 0 as a load-only tick: active <= shadow, phase unchanged, no code_stb, no wrap.
REQ-016 SHALL, on a tick with active != 0, set phase <= phase + (active step zero-extended, or truncated, to ACC_W), modulo 2^ACC_W.
REQ-017 SHALL pulse wrap for exactly one cycle on the edge where that addition carries out.
REQ-018 SHALL define raw from the accumulator MSBs, with p = phase[ACC_W-1:ACC_W-8] and t = phase[ACC_W-2:ACC_W-9]:
- mode 0, saw: raw = p.
- mode 1, triangle: raw = ~t if phase[ACC_W-1] = 1, else t.
- mode 2, square: raw = 0xFF if phase[ACC_W-1] = 1, else 0x00.
- mode 3, DC: raw = 0xFF, so that code = amplitude.
REQ-019 SHALL compute code = (raw * (amplitude + 1)) >> 8 as a 16-bit intermediate; the result always fits in 8 bits.
REQ-020 SHALL register code and pulse code_stb on the edge after an advancing tick, giving a latency of 2 clk edges from tick sampled to code valid; code SHALL hold between updates.
REQ-021 SHALL, on a mode write, set phase to 0 on the same edge and not advance phase even if tick is high; that tick produces no code_stb.
REQ-022 SHALL apply a mode write or amplitude write to the code on the next code_stb, with no update to code outside code_stb.
REQ-023 SHALL handle cfg_we together with an advancing tick on a step address as follows: the shadow write completes, and any wrap transfer to active uses the shadow contents from before that write.
REQ-024 SHALL accept back-to-back ticks, one per cycle, with full throughput.

Reset
REQ-025 SHALL, while n_rst = 0, force asynchronously: phase = 0, shadow = 0, active = 0, mode = 0, amplitude = 0xFF, code = 0x00, code_stb = 0, wrap = 0.
REQ-026 SHALL resume on the first clk edge after n_rst deasserts, with no ticks lost or replayed from before reset.

Verification
REQ-027 SHALL cover reset: n_rst low at arbitrary points, including mid-waveform with phase = 0x7000 -> code = 0x00, all pulses low, registers at their REQ-025 values.
REQ-028 SHALL cover saw: amplitude 0xFF, step 0x1000, one load tick then 16 ticks -> code sequence 0x10, 0x20, ..., 0xF0, 0x00; wrap on the 16th tick only; each code_stb 2 edges after its tick.
REQ-029 SHALL cover triangle: step 0x4000, 4 ticks -> codes 0x80, 0xFF, 0x7F, 0x00.
REQ-030 SHALL cover square: amplitude 0x7F, step 0x8000 -> codes alternate 0x7F, 0x00; DC mode with amplitude 0x40 -> 0x40 on every tick.
REQ-031 SHALL cover step change: active 0x1000, write shadow 0x2000 at phase 0x3000 -> steps of 0x1000 until wrap, then steps of 0x2000; a wrap coinciding with the write loads the old shadow.
REQ-032 SHALL cover mode write with tick in the same cycle: phase = 0, no code_stb; the next tick gives code = raw(step) in the new mode.
